// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the IF/ID/EX hazard controller: operand-source selects and
// the control FSM state encoding.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MC_WAIT  = 2'd2
    } ctrl_state_e;

    // x0 never forwards; a younger EX result shadows the writeback-side one.
    function automatic fwd_sel_e pick_src(input logic [4:0] rs,
                                          input logic       ex_hit,
                                          input logic       mem_hit);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (ex_hit) begin
                sel = FWD_EX;
            end else if (mem_hit) begin
                sel = FWD_MEM;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational operand forwarding selects and load-use hazard detection
// between the instruction in ID and the producers in EX and writeback.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1_addr,
    input  logic       id_rs1_ren,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs2_ren,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_rd_wen,
    input  logic       ex_is_load,
    input  logic       mem_valid,
    input  logic [4:0] mem_rd_addr,
    input  logic       mem_rd_wen,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel,
    output logic       load_use
);

    logic ex_fwd_ok;
    logic mem_fwd_ok;
    logic ex_load_ok;
    logic rs1_hit_load;
    logic rs2_hit_load;

    always_comb begin
        // A load's data is not ready in EX, so it can only forward from writeback.
        ex_fwd_ok   = ex_valid && ex_rd_wen && !ex_is_load;
        mem_fwd_ok  = mem_valid && mem_rd_wen;
        ex_load_ok  = ex_valid && ex_is_load && ex_rd_wen && (ex_rd_addr != 5'd0);

        fwd_rs1_sel = pick_src(id_rs1_addr,
                               ex_fwd_ok && (ex_rd_addr == id_rs1_addr),
                               mem_fwd_ok && (mem_rd_addr == id_rs1_addr));
        fwd_rs2_sel = pick_src(id_rs2_addr,
                               ex_fwd_ok && (ex_rd_addr == id_rs2_addr),
                               mem_fwd_ok && (mem_rd_addr == id_rs2_addr));

        rs1_hit_load = id_rs1_ren && (id_rs1_addr == ex_rd_addr);
        rs2_hit_load = id_rs2_ren && (id_rs2_addr == ex_rd_addr);
        load_use     = id_valid && ex_load_ok && (rs1_hit_load || rs2_hit_load);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the IF/ID/EX core: stalls, flushes, branch redirect,
// multicycle-EX wait with timeout, and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1_addr,
    input  logic            id_rs1_ren,
    input  logic [4:0]      id_rs2_addr,
    input  logic            id_rs2_ren,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_rd_wen,
    input  logic            ex_is_load,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_rd_wen,
    input  logic            ex_br_taken,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic            ex_mc_start,
    input  logic            ex_mc_done,
    input  logic            if_imem_ready,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      fwd_rs1_sel,
    output logic [1:0]      fwd_rs2_sel,
    output logic            mc_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TW = $clog2(MC_TIMEOUT + 1);

    ctrl_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             mc_err_q, mc_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       load_use;
    logic [1:0] fu_rs1_sel;
    logic [1:0] fu_rs2_sel;

    hazard_fwd_unit u_fwd (
        .id_valid    (id_valid),
        .id_rs1_addr (id_rs1_addr),
        .id_rs1_ren  (id_rs1_ren),
        .id_rs2_addr (id_rs2_addr),
        .id_rs2_ren  (id_rs2_ren),
        .ex_valid    (ex_valid),
        .ex_rd_addr  (ex_rd_addr),
        .ex_rd_wen   (ex_rd_wen),
        .ex_is_load  (ex_is_load),
        .mem_valid   (mem_valid),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_wen  (mem_rd_wen),
        .fwd_rs1_sel (fu_rs1_sel),
        .fwd_rs2_sel (fu_rs2_sel),
        .load_use    (load_use)
    );

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        mc_err_d         = mc_err_q;
        stall_if         = 1'b0;
        stall_id         = 1'b0;
        stall_ex         = 1'b0;
        flush_id         = 1'b0;
        flush_ex         = 1'b0;

        unique case (state_q)
            RUN: begin
                if (ex_br_taken) begin
                    flush_id         = 1'b1;
                    flush_ex         = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ex_br_target;
                    state_d          = REDIRECT;
                end else if (ex_mc_start && !ex_mc_done) begin
                    timer_d = '0;
                    state_d = MC_WAIT;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (!if_imem_ready) begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                end
            end
            REDIRECT: begin
                flush_id = 1'b1;
                state_d  = RUN;
            end
            MC_WAIT: begin
                if (ex_mc_done) begin
                    state_d = RUN;
                end else if (timer_q == TW'(MC_TIMEOUT - 1)) begin
                    // Abort: bubble the hung op out of EX but keep ID/IF held this cycle.
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                    mc_err_d = 1'b1;
                    state_d  = RUN;
                end else begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    timer_d  = timer_q + TW'(1);
                end
            end
            default: state_d = RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Hold every combinational control quiet while reset is asserted.
        if (rst) begin
            stall_if = 1'b0;
            stall_id = 1'b0;
            stall_ex = 1'b0;
            flush_id = 1'b0;
            flush_ex = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            timer_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mc_err_q         <= 1'b0;
            stall_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mc_err_q         <= mc_err_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mc_err         = mc_err_q;
    assign stall_cnt      = stall_cnt_q;
    assign fwd_rs1_sel    = rst ? FWD_RF : fu_rs1_sel;
    assign fwd_rs2_sel    = rst ? FWD_RF : fu_rs2_sel;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default, and short timeout with a
// narrow counter) compared every cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        id_valid, id_rs1_ren, id_rs2_ren;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic        ex_valid, ex_rd_wen, ex_is_load;
    logic [4:0]  ex_rd_addr;
    logic        mem_valid, mem_rd_wen;
    logic [4:0]  mem_rd_addr;
    logic        ex_br_taken;
    logic [63:0] ex_br_target;
    logic        ex_mc_start, ex_mc_done, if_imem_ready;

    logic [1:0]  stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o;
    logic [1:0]  rv_o, err_o;
    logic [63:0] rpc_o [2];
    logic [1:0]  f1_o [2];
    logic [1:0]  f2_o [2];
    logic [31:0] cnt0;
    logic [3:0]  cnt1;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs1_ren(id_rs1_ren),
        .id_rs2_addr(id_rs2_addr), .id_rs2_ren(id_rs2_ren),
        .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
        .ex_is_load(ex_is_load), .mem_valid(mem_valid), .mem_rd_addr(mem_rd_addr),
        .mem_rd_wen(mem_rd_wen), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .if_imem_ready(if_imem_ready),
        .stall_if(stall_if_o[0]), .stall_id(stall_id_o[0]), .stall_ex(stall_ex_o[0]),
        .flush_id(flush_id_o[0]), .flush_ex(flush_ex_o[0]),
        .redirect_valid(rv_o[0]), .redirect_pc(rpc_o[0]),
        .fwd_rs1_sel(f1_o[0]), .fwd_rs2_sel(f2_o[0]),
        .mc_err(err_o[0]), .stall_cnt(cnt0)
    );

    pipe_hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) dut_t8 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs1_ren(id_rs1_ren),
        .id_rs2_addr(id_rs2_addr), .id_rs2_ren(id_rs2_ren),
        .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
        .ex_is_load(ex_is_load), .mem_valid(mem_valid), .mem_rd_addr(mem_rd_addr),
        .mem_rd_wen(mem_rd_wen), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .if_imem_ready(if_imem_ready),
        .stall_if(stall_if_o[1]), .stall_id(stall_id_o[1]), .stall_ex(stall_ex_o[1]),
        .flush_id(flush_id_o[1]), .flush_ex(flush_ex_o[1]),
        .redirect_valid(rv_o[1]), .redirect_pc(rpc_o[1]),
        .fwd_rs1_sel(f1_o[1]), .fwd_rs2_sel(f2_o[1]),
        .mc_err(err_o[1]), .stall_cnt(cnt1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = normal, 1 = redirecting, 2 = waiting on multicycle op.
    int          m_mode  [2];
    int          m_timer [2];
    bit          m_rv    [2];
    logic [63:0] m_pc    [2];
    bit          m_err   [2];
    longint      m_cnt   [2];
    int          to_val  [2] = '{64, 8};
    longint      cnt_max [2] = '{64'hFFFF_FFFF, 64'd15};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int src_of(input logic [4:0] rs);
        if (rs == 5'd0) return 0;
        if (ex_valid && ex_rd_wen && !ex_is_load && ex_rd_addr == rs) return 1;
        if (mem_valid && mem_rd_wen && mem_rd_addr == rs) return 2;
        return 0;
    endfunction

    function automatic bit lu_hazard();
        return id_valid && ex_valid && ex_is_load && ex_rd_wen && ex_rd_addr != 5'd0 &&
               ((id_rs1_ren && id_rs1_addr == ex_rd_addr) ||
                (id_rs2_ren && id_rs2_addr == ex_rd_addr));
    endfunction

    task automatic eval(input int k, output bit sif, output bit sid, output bit sex,
                        output bit fid, output bit fex);
        sif = 0; sid = 0; sex = 0; fid = 0; fex = 0;
        if (!rst) begin
            if (m_mode[k] == 0) begin
                if (ex_br_taken) begin
                    fid = 1; fex = 1;
                end else if (ex_mc_start && !ex_mc_done) begin
                    sif = 0;
                end else if (lu_hazard()) begin
                    sif = 1; sid = 1; fex = 1;
                end else if (!if_imem_ready) begin
                    sif = 1; fid = 1;
                end
            end else if (m_mode[k] == 1) begin
                fid = 1;
            end else if (!ex_mc_done) begin
                sif = 1; sid = 1;
                if (m_timer[k] == to_val[k] - 1) fex = 1;
                else sex = 1;
            end
        end
    endtask

    task automatic check_all();
        bit sif, sid, sex, fid, fex;
        for (int k = 0; k < 2; k++) begin
            eval(k, sif, sid, sex, fid, fex);
            chk($sformatf("stall_if[%0d]", k), 64'(stall_if_o[k]), 64'(sif));
            chk($sformatf("stall_id[%0d]", k), 64'(stall_id_o[k]), 64'(sid));
            chk($sformatf("stall_ex[%0d]", k), 64'(stall_ex_o[k]), 64'(sex));
            chk($sformatf("flush_id[%0d]", k), 64'(flush_id_o[k]), 64'(fid));
            chk($sformatf("flush_ex[%0d]", k), 64'(flush_ex_o[k]), 64'(fex));
            chk($sformatf("redir_v[%0d]", k), 64'(rv_o[k]), 64'(m_rv[k]));
            chk($sformatf("redir_pc[%0d]", k), rpc_o[k], m_pc[k]);
            chk($sformatf("fwd1[%0d]", k), 64'(f1_o[k]), rst ? 64'd0 : 64'(src_of(id_rs1_addr)));
            chk($sformatf("fwd2[%0d]", k), 64'(f2_o[k]), rst ? 64'd0 : 64'(src_of(id_rs2_addr)));
            chk($sformatf("mc_err[%0d]", k), 64'(err_o[k]), 64'(m_err[k]));
            chk($sformatf("stall_cnt[%0d]", k), (k == 0) ? 64'(cnt0) : 64'(cnt1), 64'(m_cnt[k]));
        end
    endtask

    task automatic commit();
        bit sif, sid, sex, fid, fex;
        for (int k = 0; k < 2; k++) begin
            eval(k, sif, sid, sex, fid, fex);
            if (rst) begin
                m_mode[k] = 0; m_timer[k] = 0; m_rv[k] = 0; m_pc[k] = '0;
                m_err[k] = 0; m_cnt[k] = 0;
            end else begin
                if (sid && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
                m_rv[k] = 0;
                case (m_mode[k])
                    0: if (ex_br_taken) begin
                           m_rv[k] = 1; m_pc[k] = ex_br_target; m_mode[k] = 1;
                       end else if (ex_mc_start && !ex_mc_done) begin
                           m_mode[k] = 2; m_timer[k] = 0;
                       end
                    1: m_mode[k] = 0;
                    default: if (ex_mc_done) m_mode[k] = 0;
                             else if (m_timer[k] == to_val[k] - 1) begin
                                 m_err[k] = 1; m_mode[k] = 0;
                             end else m_timer[k]++;
                endcase
            end
        end
    endtask

    task automatic cycle();
        #2;
        check_all();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic quiet();
        rst = 0; id_valid = 0; id_rs1_addr = 0; id_rs1_ren = 0; id_rs2_addr = 0;
        id_rs2_ren = 0; ex_valid = 0; ex_rd_addr = 0; ex_rd_wen = 0; ex_is_load = 0;
        mem_valid = 0; mem_rd_addr = 0; mem_rd_wen = 0; ex_br_taken = 0;
        ex_br_target = '0; ex_mc_start = 0; ex_mc_done = 0; if_imem_ready = 1;
    endtask

    initial begin
        quiet();
        rst = 1;
        @(posedge clk);
        commit();
        #1;
        cycle();
        // Reset state
        rst = 0;
        #1;
        chk("rst_cnt", 64'(cnt0), 64'd0);
        chk("rst_redir", 64'(rv_o), 64'd0);
        cycle();

        // EX forwarding, then EX rd=0 gives register file
        id_valid = 1; id_rs1_addr = 5; id_rs1_ren = 1;
        ex_valid = 1; ex_rd_addr = 5; ex_rd_wen = 1;
        #1; chk("fwd_ex", 64'(f1_o[0]), 64'd1);
        cycle();
        ex_rd_addr = 0;
        #1; chk("fwd_rd0", 64'(f1_o[0]), 64'd0);
        cycle();

        // Load-use: one stall, then the load forwards from writeback
        quiet();
        id_valid = 1; id_rs2_addr = 7; id_rs2_ren = 1;
        ex_valid = 1; ex_rd_addr = 7; ex_rd_wen = 1; ex_is_load = 1;
        #1; chk("lu_stall", 64'({stall_if_o[0], stall_id_o[0], flush_ex_o[0]}), 64'b111);
        cycle();
        ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_rd_addr = 7; mem_rd_wen = 1;
        #1; chk("lu_fwd_mem", 64'(f2_o[0]), 64'd2);
        chk("lu_nostall", 64'(stall_id_o[0]), 64'd0);
        cycle();

        // Taken branch
        quiet();
        ex_br_taken = 1; ex_br_target = 64'h8000_0040;
        #1; chk("br_flush", 64'({flush_id_o[0], flush_ex_o[0]}), 64'b11);
        cycle();
        ex_br_taken = 0;
        #1; chk("br_rv", 64'(rv_o[0]), 64'd1);
        chk("br_pc", rpc_o[0], 64'h8000_0040);
        cycle();
        #1; chk("br_quiet", 64'({rv_o[0], flush_id_o[0]}), 64'd0);
        cycle();

        // Multicycle op completing after 10 stalled cycles; short instance times out
        rst = 1; cycle(); rst = 0;
        ex_mc_start = 1; cycle(); ex_mc_start = 0;
        repeat (10) cycle();
        ex_mc_done = 1;
        #1; chk("mc_done_drop", 64'(stall_ex_o[0]), 64'd0);
        cycle();
        ex_mc_done = 0;
        chk("mc_cnt", 64'(cnt0), 64'd10);
        chk("mc_noerr", 64'(err_o[0]), 64'd0);
        chk("mc_timeout_err", 64'(err_o[1]), 64'd1);
        chk("mc_timeout_cnt", 64'(cnt1), 64'd8);
        cycle();

        // Start and done together: no wait
        ex_mc_start = 1; ex_mc_done = 1; cycle(); quiet();
        #1; chk("mc_same_cycle", 64'(stall_if_o), 64'd0);
        cycle();

        // Fetch miss
        if_imem_ready = 0;
        #1; chk("fetch_miss", 64'({stall_if_o[0], flush_id_o[0], stall_id_o[0]}), 64'b110);
        cycle(); quiet();

        // Reset during MC_WAIT and during REDIRECT
        ex_mc_start = 1; cycle(); ex_mc_start = 0;
        repeat (3) cycle();
        rst = 1; cycle(); rst = 0;
        #1; chk("rst_mcwait", 64'({stall_if_o, stall_ex_o, rv_o, err_o}), 64'd0);
        cycle();
        ex_br_taken = 1; ex_br_target = 64'h1234; cycle(); ex_br_taken = 0;
        rst = 1; cycle(); rst = 0;
        #1; chk("rst_redirect", 64'({rv_o, flush_id_o, stall_if_o}), 64'd0);
        chk("rst_redirect_pc", rpc_o[0], 64'd0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 63) == 0);
            id_valid      = $urandom_range(0, 1);
            id_rs1_addr   = 5'($urandom_range(0, 3));
            id_rs1_ren    = $urandom_range(0, 1);
            id_rs2_addr   = 5'($urandom_range(0, 3));
            id_rs2_ren    = $urandom_range(0, 1);
            ex_valid      = $urandom_range(0, 1);
            ex_rd_addr    = 5'($urandom_range(0, 3));
            ex_rd_wen     = $urandom_range(0, 1);
            ex_is_load    = $urandom_range(0, 1);
            mem_valid     = $urandom_range(0, 1);
            mem_rd_addr   = 5'($urandom_range(0, 3));
            mem_rd_wen    = $urandom_range(0, 1);
            ex_br_taken   = ($urandom_range(0, 7) == 0);
            ex_br_target  = {$urandom, $urandom};
            ex_mc_start   = ($urandom_range(0, 9) == 0);
            ex_mc_done    = ($urandom_range(0, 5) == 0);
            if_imem_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
